// File: rtl/dm_port_arbiter.sv
// Round-robin two-master sequencer in front of the single-port word data memory.
// One transaction per ACCESS slot; memory port and master responses are registered.
module dm_port_arbiter #(
    parameter int AW          = 12,
    parameter int DEPTH_WORDS = 3072
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [31:0]   m0_addr,
    input  logic [31:0]   m0_wdata,
    input  logic [3:0]    m0_be,
    output logic          m0_ack,
    output logic          m0_err,
    output logic [31:0]   m0_rdata,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [31:0]   m1_addr,
    input  logic [31:0]   m1_wdata,
    input  logic [3:0]    m1_be,
    output logic          m1_ack,
    output logic          m1_err,
    output logic [31:0]   m1_rdata,

    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);

    state_t      state;
    logic        win;       // master owning the current transaction
    logic        last_m1;   // 1 when m1 was granted last
    logic        lat_we;
    logic        lat_inrange;

    logic        el0, el1, any_el, pick;
    logic        sel_we, sel_inrange;
    logic [31:0] sel_addr, sel_wdata;
    logic [3:0]  sel_be;
    logic [31:0] cap_data;

    logic        unused_addr_lsbs;
    assign unused_addr_lsbs = &{1'b0, m0_addr[1:0], m1_addr[1:0]};

    // The master just acked presents a stale request during ACK; mask it.
    always_comb begin
        el0         = m0_req & ~((state == ACK) & ~win);
        el1         = m1_req & ~((state == ACK) &  win);
        any_el      = el0 | el1;
        pick        = (el0 & el1) ? ~last_m1 : el1;
        sel_we      = pick ? m1_we    : m0_we;
        sel_addr    = pick ? m1_addr  : m0_addr;
        sel_wdata   = pick ? m1_wdata : m0_wdata;
        sel_be      = pick ? m1_be    : m0_be;
        sel_inrange = (sel_addr[31:2] < DEPTH_W);
        cap_data    = (~lat_we & lat_inrange) ? mem_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            win         <= 1'b0;
            last_m1     <= 1'b1;
            lat_we      <= 1'b0;
            lat_inrange <= 1'b0;
            mem_we      <= 1'b0;
            mem_be      <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            m0_ack      <= 1'b0;
            m0_err      <= 1'b0;
            m0_rdata    <= '0;
            m1_ack      <= 1'b0;
            m1_err      <= 1'b0;
            m1_rdata    <= '0;
        end else begin
            m0_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_ack <= 1'b0;
            m1_err <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE, ACK: begin
                    if (any_el) begin
                        win         <= pick;
                        last_m1     <= pick;
                        lat_we      <= sel_we;
                        lat_inrange <= sel_inrange;
                        mem_addr    <= sel_addr[AW+1:2];
                        mem_wdata   <= sel_wdata;
                        mem_be      <= sel_be;
                        mem_we      <= sel_we & sel_inrange & (sel_be != 4'b0000);
                        state       <= ACCESS;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    if (win) begin
                        m1_ack   <= 1'b1;
                        m1_err   <= ~lat_inrange;
                        m1_rdata <= cap_data;
                    end else begin
                        m0_ack   <= 1'b1;
                        m0_err   <= ~lat_inrange;
                        m0_rdata <= cap_data;
                    end
                    state <= ACK;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
